// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN input-path channel sequencer.
package cnn_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } seq_state_t;

   localparam logic [1:0] CH0    = 2'b00;
   localparam logic [1:0] CH1    = 2'b01;
   localparam logic [1:0] CH2    = 2'b10;
   localparam int         NUM_CH = 3;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with clear and enable; o_wrap flags the enabled step
// that rolls the count back to zero, so counters can be chained.
module wrap_counter #(
   parameter int WIDTH  = 2,
   parameter int MODULO = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == LAST);
   assign o_wrap    = i_en & w_at_last;
   assign o_count   = r_count;

   // count register: reset and clear dominate, otherwise step on enable
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= {WIDTH{1'b0}};
      end else if (i_clr) begin
         r_count <= {WIDTH{1'b0}};
      end else if (i_en) begin
         if (w_at_last) begin
            r_count <= {WIDTH{1'b0}};
         end else begin
            r_count <= r_count + WIDTH'(1);
         end
      end else begin
         r_count <= r_count;
      end
   end

endmodule

// File: rtl/pixel_channel_sequencer.sv
// Feeds the 1-to-3 channel demux from an interleaved C0/C1/C2 pixel stream,
// tracking channel, column and row across one frame.
module pixel_channel_sequencer import cnn_seq_pkg::*; #(
   parameter  int DATA_WIDTH = 8,
   parameter  int IMG_WIDTH  = 28,
   parameter  int IMG_HEIGHT = 28,
   localparam int COL_W      = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
   localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  SEQ_Start,
   input  logic [DATA_WIDTH-1:0] SEQ_Data_in,
   input  logic                  SEQ_Valid,
   output logic                  SEQ_Ready,
   input  logic                  SEQ_Stall,
   output logic [DATA_WIDTH-1:0] SEQ_Data_out,
   output logic [1:0]            SEQ_Selector,
   output logic                  SEQ_En,
   output logic [COL_W-1:0]      SEQ_Col,
   output logic [ROW_W-1:0]      SEQ_Row,
   output logic                  SEQ_Busy,
   output logic                  SEQ_Frame_done
);

   seq_state_t r_state;
   seq_state_t w_state_nxt;

   logic                  w_ready;
   logic                  w_accept;
   logic                  w_clr;
   logic [1:0]            w_chan;
   logic [COL_W-1:0]      w_col;
   logic [ROW_W-1:0]      w_row;
   logic                  w_chan_wrap;
   logic                  w_col_wrap;
   logic                  w_last;

   logic                  r_en;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_sel;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;

   assign w_ready  = (r_state == RUN) & ~SEQ_Stall;
   assign w_accept = SEQ_Valid & w_ready;
   assign w_clr    = (r_state == IDLE) & SEQ_Start;

   wrap_counter #(.WIDTH(2), .MODULO(NUM_CH)) u_chan_cnt (
      .i_clk(CLOCK_50), .i_rst(RESET), .i_clr(w_clr),
      .i_en(w_accept), .o_count(w_chan), .o_wrap(w_chan_wrap)
   );

   wrap_counter #(.WIDTH(COL_W), .MODULO(IMG_WIDTH)) u_col_cnt (
      .i_clk(CLOCK_50), .i_rst(RESET), .i_clr(w_clr),
      .i_en(w_chan_wrap), .o_count(w_col), .o_wrap(w_col_wrap)
   );

   // the row wrap can only fire on the final word of the frame
   wrap_counter #(.WIDTH(ROW_W), .MODULO(IMG_HEIGHT)) u_row_cnt (
      .i_clk(CLOCK_50), .i_rst(RESET), .i_clr(w_clr),
      .i_en(w_col_wrap), .o_count(w_row), .o_wrap(w_last)
   );

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (SEQ_Start) w_state_nxt = RUN;
            else           w_state_nxt = IDLE;
         end
         RUN: begin
            if (w_last) w_state_nxt = DONE;
            else        w_state_nxt = RUN;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLOCK_50) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // output stage: word and position of the last accepted beat hold until the next one
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_en   <= 1'b0;
         r_data <= {DATA_WIDTH{1'b0}};
         r_sel  <= CH0;
         r_col  <= {COL_W{1'b0}};
         r_row  <= {ROW_W{1'b0}};
      end else begin
         r_en <= w_accept;
         if (w_accept) begin
            r_data <= SEQ_Data_in;
            r_sel  <= w_chan;
            r_col  <= w_col;
            r_row  <= w_row;
         end else begin
            r_data <= r_data;
            r_sel  <= r_sel;
            r_col  <= r_col;
            r_row  <= r_row;
         end
      end
   end

   assign SEQ_Ready      = w_ready;
   assign SEQ_En         = r_en;
   assign SEQ_Data_out   = r_data;
   assign SEQ_Selector   = r_sel;
   assign SEQ_Col        = r_col;
   assign SEQ_Row        = r_row;
   assign SEQ_Busy       = (r_state == RUN);
   assign SEQ_Frame_done = (r_state == DONE);

endmodule

// File: tb/tb_pixel_channel_sequencer.sv
// Directed bench for pixel_channel_sequencer on a 4x2 frame (24 words).
module tb_pixel_channel_sequencer;

   localparam int DW = 8;
   localparam int IW = 4;
   localparam int IH = 2;
   localparam int NW = IW * IH * 3;

   logic          CLOCK_50 = 1'b0;
   logic          RESET;
   logic          SEQ_Start;
   logic [DW-1:0] SEQ_Data_in;
   logic          SEQ_Valid;
   logic          SEQ_Ready;
   logic          SEQ_Stall;
   logic [DW-1:0] SEQ_Data_out;
   logic [1:0]    SEQ_Selector;
   logic          SEQ_En;
   logic [1:0]    SEQ_Col;
   logic [0:0]    SEQ_Row;
   logic          SEQ_Busy;
   logic          SEQ_Frame_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] cap_data [512];
   logic [1:0]    cap_sel  [512];
   int            cap_col  [512];
   int            cap_row  [512];
   int            cap_cyc  [512];
   int            cap_n  = 0;
   int            done_n = 0;
   int            busy_n = 0;
   logic [DW-1:0] done_data;
   logic          done_en;
   logic          done_ready;

   pixel_channel_sequencer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .SEQ_Start(SEQ_Start),
      .SEQ_Data_in(SEQ_Data_in), .SEQ_Valid(SEQ_Valid), .SEQ_Ready(SEQ_Ready),
      .SEQ_Stall(SEQ_Stall), .SEQ_Data_out(SEQ_Data_out), .SEQ_Selector(SEQ_Selector),
      .SEQ_En(SEQ_En), .SEQ_Col(SEQ_Col), .SEQ_Row(SEQ_Row), .SEQ_Busy(SEQ_Busy),
      .SEQ_Frame_done(SEQ_Frame_done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // record every emitted word, frame-done pulse and busy cycle
   always @(negedge CLOCK_50) begin
      if (SEQ_En && cap_n < 512) begin
         cap_data[cap_n] <= SEQ_Data_out;
         cap_sel[cap_n]  <= SEQ_Selector;
         cap_col[cap_n]  <= int'(SEQ_Col);
         cap_row[cap_n]  <= int'(SEQ_Row);
         cap_cyc[cap_n]  <= cyc;
         cap_n           <= cap_n + 1;
      end
      if (SEQ_Frame_done) begin
         done_n     <= done_n + 1;
         done_data  <= SEQ_Data_out;
         done_en    <= SEQ_En;
         done_ready <= SEQ_Ready;
      end
      if (SEQ_Busy) busy_n <= busy_n + 1;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Start pulse then words 1..NW; optional random valid gaps, early abort, Start spam
   task automatic feed(input bit gaps, input int abort_at, input bit spam, output int start_cyc);
      int k;
      int guard;
      k = 1;
      guard = 0;
      @(negedge CLOCK_50);
      start_cyc   = cyc;
      SEQ_Start   = 1'b1;
      SEQ_Valid   = 1'b1;
      SEQ_Stall   = 1'b0;
      SEQ_Data_in = 8'd1;
      while (k <= NW && k != abort_at && guard < 400) begin
         @(negedge CLOCK_50);
         SEQ_Start   = spam && (guard % 4 == 1);
         SEQ_Valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         SEQ_Data_in = 8'(k);
         #1;
         if (SEQ_Valid && SEQ_Ready) k++;
         guard++;
      end
      @(negedge CLOCK_50);
      SEQ_Start = spam;
      SEQ_Valid = 1'b0;
      @(negedge CLOCK_50);
      SEQ_Start = 1'b0;
      total++;
      if (guard >= 400) begin
         bad++;
         $display("FAIL feed_timeout got words=%0d want %0d", k - 1, NW);
      end
   endtask

   task automatic test_reset();
      int b;
      RESET = 1'b1; SEQ_Start = 1'b0; SEQ_Valid = 1'b1; SEQ_Stall = 1'b0; SEQ_Data_in = 8'hAA;
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (SEQ_En !== 1'b0 || SEQ_Ready !== 1'b0) begin
         bad++; $display("FAIL reset_en_ready got en=%b rdy=%b want 0 0", SEQ_En, SEQ_Ready);
      end
      total++;
      if (SEQ_Data_out !== 8'h00 || SEQ_Selector !== 2'b00 || SEQ_Col !== 2'b00 || SEQ_Row !== 1'b0) begin
         bad++; $display("FAIL reset_outputs got d=%h s=%b c=%0d r=%0d want 0", SEQ_Data_out, SEQ_Selector, SEQ_Col, SEQ_Row);
      end
      total++;
      if (SEQ_Busy !== 1'b0 || SEQ_Frame_done !== 1'b0) begin
         bad++; $display("FAIL reset_status got busy=%b done=%b want 0 0", SEQ_Busy, SEQ_Frame_done);
      end
      RESET = 1'b0;
      b = cap_n;
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (SEQ_Ready !== 1'b0 || cap_n != b) begin
         bad++; $display("FAIL idle_no_accept got rdy=%b words=%0d want 0 0", SEQ_Ready, cap_n - b);
      end
      SEQ_Valid = 1'b0;
   endtask

   task automatic test_full_frame();
      int b, d0, bu0, sc;
      b = cap_n; d0 = done_n; bu0 = busy_n;
      feed(1'b0, 0, 1'b0, sc);
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (cap_n - b != NW) begin
         bad++; $display("FAIL full_count got %0d want %0d", cap_n - b, NW);
      end
      total++;
      if (cap_cyc[b] != sc + 2 || cap_cyc[b+NW-1] != sc + 1 + NW) begin
         bad++; $display("FAIL full_timing got first=%0d last=%0d want %0d %0d", cap_cyc[b] - sc, cap_cyc[b+NW-1] - sc, 2, NW + 1);
      end
      for (int i = 0; i < NW; i++) begin
         total++;
         if (cap_data[b+i] !== 8'(i + 1) || cap_sel[b+i] !== 2'(i % 3) ||
             cap_col[b+i] != (i / 3) % IW || cap_row[b+i] != i / (3 * IW)) begin
            bad++;
            $display("FAIL full_word%0d got d=%h s=%0d c=%0d r=%0d want d=%h s=%0d c=%0d r=%0d", i + 1,
                     cap_data[b+i], cap_sel[b+i], cap_col[b+i], cap_row[b+i], i + 1, i % 3, (i / 3) % IW, i / (3 * IW));
         end
      end
      total++;
      if (cap_data[b+12] !== 8'h0D || cap_col[b+12] != 0 || cap_row[b+12] != 1 || cap_sel[b+12] !== 2'b00) begin
         bad++; $display("FAIL full_row1_start got d=%h c=%0d r=%0d s=%0d want 0d 0 1 0", cap_data[b+12], cap_col[b+12], cap_row[b+12], cap_sel[b+12]);
      end
      total++;
      if (done_n - d0 != 1 || done_data !== 8'h18 || done_en !== 1'b1 || done_ready !== 1'b0) begin
         bad++; $display("FAIL full_done got n=%0d d=%h en=%b rdy=%b want 1 18 1 0", done_n - d0, done_data, done_en, done_ready);
      end
      total++;
      if (busy_n - bu0 != NW || SEQ_Busy !== 1'b0) begin
         bad++; $display("FAIL full_busy got cycles=%0d busy=%b want %0d 0", busy_n - bu0, SEQ_Busy, NW);
      end
   endtask

   task automatic test_stall();
      int b, d0, k, sc, guard;
      bit prev_st;
      b = cap_n; d0 = done_n; k = 1; sc = 0; guard = 0; prev_st = 1'b0;
      @(negedge CLOCK_50);
      SEQ_Start = 1'b1; SEQ_Valid = 1'b1; SEQ_Stall = 1'b0; SEQ_Data_in = 8'd1;
      while (k <= NW && guard < 200) begin
         @(negedge CLOCK_50);
         SEQ_Start = 1'b0;
         if (prev_st) begin
            total++;
            if (SEQ_En !== 1'b0) begin
               bad++; $display("FAIL stall_en got %b want 0", SEQ_En);
            end
         end
         SEQ_Stall   = (k == 5 && sc < 3);
         SEQ_Data_in = 8'(k);
         #1;
         if (SEQ_Stall) begin
            sc++;
            total++;
            if (SEQ_Ready !== 1'b0) begin
               bad++; $display("FAIL stall_ready got %b want 0", SEQ_Ready);
            end
         end else if (SEQ_Valid && SEQ_Ready) begin
            k++;
         end
         prev_st = SEQ_Stall;
         guard++;
      end
      @(negedge CLOCK_50);
      SEQ_Valid = 1'b0; SEQ_Stall = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (cap_n - b != NW || done_n - d0 != 1) begin
         bad++; $display("FAIL stall_count got words=%0d done=%0d want %0d 1", cap_n - b, done_n - d0, NW);
      end
      total++;
      if (cap_data[b+4] !== 8'd5 || cap_sel[b+4] !== 2'b01) begin
         bad++; $display("FAIL stall_word5 got d=%h s=%0d want 05 1", cap_data[b+4], cap_sel[b+4]);
      end
      for (int i = 0; i < NW; i++) begin
         total++;
         if (cap_data[b+i] !== 8'(i + 1) || cap_sel[b+i] !== 2'(i % 3) ||
             cap_col[b+i] != (i / 3) % IW || cap_row[b+i] != i / (3 * IW)) begin
            bad++;
            $display("FAIL stall_word%0d got d=%h s=%0d c=%0d r=%0d want d=%h s=%0d c=%0d r=%0d", i + 1,
                     cap_data[b+i], cap_sel[b+i], cap_col[b+i], cap_row[b+i], i + 1, i % 3, (i / 3) % IW, i / (3 * IW));
         end
      end
   endtask

   task automatic test_valid_gaps();
      int b, d0, sc;
      b = cap_n; d0 = done_n;
      feed(1'b1, 0, 1'b0, sc);
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (cap_n - b != NW || done_n - d0 != 1 || done_data !== 8'h18) begin
         bad++; $display("FAIL gaps_count got words=%0d done=%0d d=%h want %0d 1 18", cap_n - b, done_n - d0, done_data, NW);
      end
      for (int i = 0; i < NW; i++) begin
         total++;
         if (cap_data[b+i] !== 8'(i + 1) || cap_sel[b+i] !== 2'(i % 3) ||
             cap_col[b+i] != (i / 3) % IW || cap_row[b+i] != i / (3 * IW)) begin
            bad++;
            $display("FAIL gaps_word%0d got d=%h s=%0d c=%0d r=%0d want d=%h s=%0d c=%0d r=%0d", i + 1,
                     cap_data[b+i], cap_sel[b+i], cap_col[b+i], cap_row[b+i], i + 1, i % 3, (i / 3) % IW, i / (3 * IW));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int b, b2, d0, sc;
      b = cap_n; d0 = done_n;
      feed(1'b0, 10, 1'b0, sc);
      RESET = 1'b1;
      @(negedge CLOCK_50);
      total++;
      if (SEQ_Busy !== 1'b0 || SEQ_En !== 1'b0 || SEQ_Data_out !== 8'h00 || SEQ_Frame_done !== 1'b0) begin
         bad++; $display("FAIL abort_reset got busy=%b en=%b d=%h done=%b want 0 0 00 0", SEQ_Busy, SEQ_En, SEQ_Data_out, SEQ_Frame_done);
      end
      RESET = 1'b0;
      total++;
      if (cap_n - b != 9) begin
         bad++; $display("FAIL abort_partial got %0d want 9", cap_n - b);
      end
      b2 = cap_n;
      feed(1'b0, 0, 1'b0, sc);
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (cap_data[b2] !== 8'd1 || cap_sel[b2] !== 2'b00 || cap_col[b2] != 0 || cap_row[b2] != 0) begin
         bad++; $display("FAIL abort_first got d=%h s=%0d c=%0d r=%0d want 01 0 0 0", cap_data[b2], cap_sel[b2], cap_col[b2], cap_row[b2]);
      end
      total++;
      if (cap_n - b2 != NW || done_n - d0 != 1 || cap_data[b2+NW-1] !== 8'h18) begin
         bad++; $display("FAIL abort_frame got words=%0d done=%0d last=%h want %0d 1 18", cap_n - b2, done_n - d0, cap_data[b2+NW-1], NW);
      end
   endtask

   task automatic test_start_ignored();
      int b, d0, sc;
      b = cap_n; d0 = done_n;
      feed(1'b0, 0, 1'b1, sc);
      for (int i = 0; i < NW; i++) begin
         total++;
         if (cap_data[b+i] !== 8'(i + 1) || cap_sel[b+i] !== 2'(i % 3) ||
             cap_col[b+i] != (i / 3) % IW || cap_row[b+i] != i / (3 * IW)) begin
            bad++;
            $display("FAIL start_word%0d got d=%h s=%0d c=%0d r=%0d want d=%h s=%0d c=%0d r=%0d", i + 1,
                     cap_data[b+i], cap_sel[b+i], cap_col[b+i], cap_row[b+i], i + 1, i % 3, (i / 3) % IW, i / (3 * IW));
         end
      end
      SEQ_Valid = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (SEQ_Busy !== 1'b0 || cap_n - b != NW || done_n - d0 != 1) begin
         bad++; $display("FAIL start_done_ignored got busy=%b words=%0d done=%0d want 0 %0d 1", SEQ_Busy, cap_n - b, done_n - d0, NW);
      end
      SEQ_Valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_stall();
      test_valid_gaps();
      test_reset_mid_frame();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
